ysyx_23060180_mem_arbiter: RTL and testbench

YSYX_23060180_MEM_ARBITER -- requirements
Module: ysyx_23060180_mem_arbiter

---
 rtl/ysyx_23060180_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_ysyx_23060180_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060180_mem_arbiter.sv
// Two-port memory arbiter: fetch (IF) and load/store (LS) share one memory port.
// Round-robin grants in IDLE; one outstanding transaction, response after RD_LAT cycles.
module ysyx_23060180_mem_arbiter #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,

    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_wmask,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,

    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [2:0] LAT = 3'(RD_LAT);

    state_t     state;
    logic       last_ls;   // 1 = LS was granted last, 0 = IF
    logic       owner_ls;
    logic       owner_we;
    logic [2:0] cnt;

    logic       can_grant;
    logic       resp;

    // Grants and the memory command are combinational and gated by rst so
    // every output reads 0 while reset is held.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        can_grant = (state == IDLE) && !rst;
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;

        if (can_grant) begin
            if_gnt = if_req && (!ls_req || last_ls);
            ls_gnt = ls_req && (!if_req || !last_ls);
        end

        if (if_gnt) begin
            mem_rd   = 1'b1;
            mem_addr = if_addr;
        end else if (ls_gnt) begin
            mem_addr = ls_addr;
            if (ls_we) begin
                mem_wr    = 1'b1;
                mem_wdata = ls_wdata;
                mem_wmask = ls_wmask;
            end else begin
                mem_rd = 1'b1;
            end
        end
    end

    // Response slot: cnt counts 1..RD_LAT in WAIT, the RD_LAT-th cycle is the reply.
    always_comb begin
        resp      = (state == WAIT) && (cnt == LAT) && !rst;
        if_rvalid = resp && !owner_ls;
        ls_rvalid = resp && owner_ls;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        ls_rdata  = (ls_rvalid && !owner_we) ? mem_rdata : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state    <= IDLE;
            last_ls  <= 1'b0;
            owner_ls <= 1'b0;
            owner_we <= 1'b0;
            cnt      <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_gnt || ls_gnt) begin
                        state    <= WAIT;
                        owner_ls <= ls_gnt;
                        owner_we <= ls_gnt && ls_we;
                        last_ls  <= ls_gnt;
                        cnt      <= 3'd1;
                    end
                end
                WAIT: begin
                    if (cnt == LAT) begin
                        state <= IDLE;
                        cnt   <= 3'd0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060180_mem_arbiter.sv
// Bench for ysyx_23060180_mem_arbiter: RD_LAT=1 instance driven from a vector
// table plus directed sequences; RD_LAT=3 instance for latency/reset corners.
module tb_ysyx_23060180_mem_arbiter;

    // {if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_rd, mem_wr,
    //  if_rdata, ls_rdata, mem_addr, mem_wdata, mem_wmask}
    typedef logic [137:0] obs_t;

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        ls_req;
        logic        ls_we;
        logic [31:0] ls_addr;
        logic [31:0] ls_wdata;
        logic [3:0]  ls_wmask;
        logic [31:0] mem_rdata;
        obs_t        exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // RD_LAT = 1 instance
    logic        a_rst;
    logic        a_if_req, a_if_gnt, a_if_rvalid;
    logic [31:0] a_if_addr, a_if_rdata;
    logic        a_ls_req, a_ls_we, a_ls_gnt, a_ls_rvalid;
    logic [31:0] a_ls_addr, a_ls_wdata, a_ls_rdata;
    logic [3:0]  a_ls_wmask;
    logic        a_mem_rd, a_mem_wr;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [3:0]  a_mem_wmask;

    ysyx_23060180_mem_arbiter #(.RD_LAT(1)) dut_a (
        .clk(clk), .rst(a_rst),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
        .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
        .ls_req(a_ls_req), .ls_we(a_ls_we), .ls_addr(a_ls_addr),
        .ls_wdata(a_ls_wdata), .ls_wmask(a_ls_wmask), .ls_gnt(a_ls_gnt),
        .ls_rvalid(a_ls_rvalid), .ls_rdata(a_ls_rdata),
        .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_wmask(a_mem_wmask), .mem_rdata(a_mem_rdata)
    );

    // RD_LAT = 3 instance
    logic        b_rst;
    logic        b_if_req, b_if_gnt, b_if_rvalid;
    logic [31:0] b_if_addr, b_if_rdata;
    logic        b_ls_req, b_ls_we, b_ls_gnt, b_ls_rvalid;
    logic [31:0] b_ls_addr, b_ls_wdata, b_ls_rdata;
    logic [3:0]  b_ls_wmask;
    logic        b_mem_rd, b_mem_wr;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [3:0]  b_mem_wmask;

    ysyx_23060180_mem_arbiter #(.RD_LAT(3)) dut_b (
        .clk(clk), .rst(b_rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
        .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .ls_req(b_ls_req), .ls_we(b_ls_we), .ls_addr(b_ls_addr),
        .ls_wdata(b_ls_wdata), .ls_wmask(b_ls_wmask), .ls_gnt(b_ls_gnt),
        .ls_rvalid(b_ls_rvalid), .ls_rdata(b_ls_rdata),
        .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask), .mem_rdata(b_mem_rdata)
    );

    function automatic obs_t obs_a();
        return {a_if_gnt, a_ls_gnt, a_if_rvalid, a_ls_rvalid, a_mem_rd, a_mem_wr,
                a_if_rdata, a_ls_rdata, a_mem_addr, a_mem_wdata, a_mem_wmask};
    endfunction

    function automatic obs_t obs_b();
        return {b_if_gnt, b_ls_gnt, b_if_rvalid, b_ls_rvalid, b_mem_rd, b_mem_wr,
                b_if_rdata, b_ls_rdata, b_mem_addr, b_mem_wdata, b_mem_wmask};
    endfunction

    function automatic obs_t exp_o(input logic ig, lg, irv, lrv, mrd, mwr,
                                   input logic [31:0] ird, lrd, ma, mwd,
                                   input logic [3:0] mm);
        return {ig, lg, irv, lrv, mrd, mwr, ird, lrd, ma, mwd, mm};
    endfunction

    function automatic vec_t mkv(input logic ir, input logic [31:0] ia,
                                 input logic lr, lw, input logic [31:0] la, lwd,
                                 input logic [3:0] lm, input logic [31:0] rd,
                                 input obs_t e);
        vec_t v;
        v.if_req = ir;  v.if_addr = ia;
        v.ls_req = lr;  v.ls_we = lw;  v.ls_addr = la;
        v.ls_wdata = lwd;  v.ls_wmask = lm;  v.mem_rdata = rd;  v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Settle, compare, then advance to just after the next rising edge.
    task automatic a_cyc(input string name, input obs_t exp);
        #1 check(name, obs_a(), exp);
        @(posedge clk); #1;
    endtask

    task automatic b_cyc(input string name, input obs_t exp);
        #1 check(name, obs_b(), exp);
        @(posedge clk); #1;
    endtask

    localparam obs_t ZERO = '0;

    vec_t vecs[$];

    initial begin
        a_rst = 1'b1; b_rst = 1'b1;
        a_if_req = 0; a_if_addr = 0; a_ls_req = 0; a_ls_we = 0;
        a_ls_addr = 0; a_ls_wdata = 0; a_ls_wmask = 0; a_mem_rdata = 0;
        b_if_req = 0; b_if_addr = 0; b_ls_req = 0; b_ls_we = 0;
        b_ls_addr = 0; b_ls_wdata = 0; b_ls_wmask = 0; b_mem_rdata = 0;

        //              ir ia            lr lw la            lwd           lm    rd
        vecs.push_back(mkv(0, 32'h0,         0, 0, 32'h0,         32'h0,        4'h0, 32'h0,
            exp_o(0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0)));
        vecs.push_back(mkv(1, 32'h8000_0000, 0, 0, 32'h0,         32'h0,        4'h0, 32'h0,
            exp_o(1,0,0,0,1,0, 32'h0, 32'h0, 32'h8000_0000, 32'h0, 4'h0)));
        vecs.push_back(mkv(0, 32'h0,         0, 0, 32'h0,         32'h0,        4'h0, 32'h1234_5678,
            exp_o(0,0,1,0,0,0, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 4'h0)));
        vecs.push_back(mkv(0, 32'h0,         1, 0, 32'h8000_0010, 32'h0,        4'h0, 32'hAAAA_AAAA,
            exp_o(0,1,0,0,1,0, 32'h0, 32'h0, 32'h8000_0010, 32'h0, 4'h0)));
        vecs.push_back(mkv(1, 32'h8000_0004, 0, 0, 32'h0,         32'h0,        4'h0, 32'hCAFE_F00D,
            exp_o(0,0,0,1,0,0, 32'h0, 32'hCAFE_F00D, 32'h0, 32'h0, 4'h0)));
        vecs.push_back(mkv(1, 32'h8000_0004, 1, 1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 32'h0,
            exp_o(1,0,0,0,1,0, 32'h0, 32'h0, 32'h8000_0004, 32'h0, 4'h0)));
        vecs.push_back(mkv(0, 32'h0,         1, 1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 32'h1111_2222,
            exp_o(0,0,1,0,0,0, 32'h1111_2222, 32'h0, 32'h0, 32'h0, 4'h0)));
        vecs.push_back(mkv(0, 32'h0,         1, 1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 32'h9999_9999,
            exp_o(0,1,0,0,0,1, 32'h0, 32'h0, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF)));
        vecs.push_back(mkv(0, 32'h0,         0, 0, 32'h0,         32'h0,        4'h0, 32'h5555_5555,
            exp_o(0,0,0,1,0,0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0)));
        vecs.push_back(mkv(0, 32'h0,         1, 1, 32'h8000_1004, 32'h0102_0304, 4'h0, 32'h0,
            exp_o(0,1,0,0,0,1, 32'h0, 32'h0, 32'h8000_1004, 32'h0102_0304, 4'h0)));
        vecs.push_back(mkv(1, 32'h8000_0040, 0, 0, 32'h0,         32'h0,        4'h0, 32'hFFFF_FFFF,
            exp_o(0,0,0,1,0,0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0)));
        vecs.push_back(mkv(0, 32'h0,         0, 0, 32'h0,         32'h0,        4'h0, 32'h7777_7777,
            exp_o(0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0)));
        vecs.push_back(mkv(1, 32'h8000_0008, 1, 0, 32'h8000_0020, 32'h0,        4'h0, 32'h0,
            exp_o(1,0,0,0,1,0, 32'h0, 32'h0, 32'h8000_0008, 32'h0, 4'h0)));
        vecs.push_back(mkv(0, 32'h0,         1, 0, 32'h8000_0020, 32'h0,        4'h0, 32'h0A0B_0C0D,
            exp_o(0,0,1,0,0,0, 32'h0A0B_0C0D, 32'h0, 32'h0, 32'h0, 4'h0)));
        vecs.push_back(mkv(1, 32'h8000_000C, 1, 0, 32'h8000_0020, 32'h0,        4'h0, 32'h0,
            exp_o(0,1,0,0,1,0, 32'h0, 32'h0, 32'h8000_0020, 32'h0, 4'h0)));
        vecs.push_back(mkv(1, 32'h8000_000C, 0, 0, 32'h0,         32'h0,        4'h0, 32'h1357_2468,
            exp_o(0,0,0,1,0,0, 32'h0, 32'h1357_2468, 32'h0, 32'h0, 4'h0)));
        vecs.push_back(mkv(1, 32'h8000_000C, 0, 0, 32'h0,         32'h0,        4'h0, 32'h0,
            exp_o(1,0,0,0,1,0, 32'h0, 32'h0, 32'h8000_000C, 32'h0, 4'h0)));
        vecs.push_back(mkv(0, 32'h0,         0, 0, 32'h0,         32'h0,        4'h0, 32'h2468_ACE0,
            exp_o(0,0,1,0,0,0, 32'h2468_ACE0, 32'h0, 32'h0, 32'h0, 4'h0)));

        @(posedge clk); #1;
        // Contention from reset: both requesters held through reset release.
        a_if_req = 1; a_if_addr = 32'h8000_0000;
        a_ls_req = 1; a_ls_addr = 32'h8000_0800; a_mem_rdata = 32'hFEED_0001;
        #1 check("a_reset_outputs", obs_a(), ZERO);
        check("b_reset_outputs", obs_b(), ZERO);
        @(posedge clk); #1;
        a_rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            logic [1:0] exp_g;
            case (k % 4)
                0:       exp_g = 2'b01;
                2:       exp_g = 2'b10;
                default: exp_g = 2'b00;
            endcase
            #1 check($sformatf("contend_cyc%0d", k), obs_t'({a_if_gnt, a_ls_gnt}), obs_t'(exp_g));
            @(posedge clk); #1;
        end
        a_if_req = 0; a_ls_req = 0; a_mem_rdata = 0;
        a_rst = 1'b1;
        @(posedge clk); #1;
        a_rst = 1'b0;

        foreach (vecs[i]) begin
            a_if_req    = vecs[i].if_req;
            a_if_addr   = vecs[i].if_addr;
            a_ls_req    = vecs[i].ls_req;
            a_ls_we     = vecs[i].ls_we;
            a_ls_addr   = vecs[i].ls_addr;
            a_ls_wdata  = vecs[i].ls_wdata;
            a_ls_wmask  = vecs[i].ls_wmask;
            a_mem_rdata = vecs[i].mem_rdata;
            a_cyc($sformatf("vec%0d", i), vecs[i].exp);
        end

        // RD_LAT=3: fetch arriving during an LS load waits for IDLE.
        b_rst = 1'b0;
        b_ls_req = 1; b_ls_addr = 32'h8000_2000;
        b_cyc("lat3_ls_gnt", exp_o(0,1,0,0,1,0, 32'h0, 32'h0, 32'h8000_2000, 32'h0, 4'h0));
        b_ls_req = 0; b_if_req = 1; b_if_addr = 32'h8000_0100;
        b_cyc("lat3_t1", ZERO);
        b_cyc("lat3_t2", ZERO);
        b_mem_rdata = 32'h3333_0001;
        b_cyc("lat3_t3_rvalid", exp_o(0,0,0,1,0,0, 32'h0, 32'h3333_0001, 32'h0, 32'h0, 4'h0));
        b_mem_rdata = 32'h0;
        b_cyc("lat3_t4_if_gnt", exp_o(1,0,0,0,1,0, 32'h0, 32'h0, 32'h8000_0100, 32'h0, 4'h0));
        b_if_req = 0;
        b_cyc("lat3_t5", ZERO);
        b_cyc("lat3_t6", ZERO);
        b_mem_rdata = 32'h3333_0002;
        b_cyc("lat3_t7_if_rvalid", exp_o(0,0,1,0,0,0, 32'h3333_0002, 32'h0, 32'h0, 32'h0, 4'h0));

        // Reset one cycle into an RD_LAT=3 load: aborted, last-granted back to IF.
        b_mem_rdata = 32'h0;
        b_ls_req = 1; b_ls_addr = 32'h8000_3000;
        b_cyc("rst_ls_gnt", exp_o(0,1,0,0,1,0, 32'h0, 32'h0, 32'h8000_3000, 32'h0, 4'h0));
        b_rst = 1'b1;
        b_if_req = 1; b_if_addr = 32'h8000_0200;
        b_ls_addr = 32'h8000_3004; b_mem_rdata = 32'h4444_4444;
        b_cyc("rst_hold1", ZERO);
        b_cyc("rst_hold2", ZERO);
        b_cyc("rst_hold3", ZERO);
        b_rst = 1'b0;
        b_cyc("rst_fresh_gnt", exp_o(0,1,0,0,1,0, 32'h0, 32'h0, 32'h8000_3004, 32'h0, 4'h0));
        b_if_req = 0; b_ls_req = 0;
        b_cyc("rst_after1", ZERO);
        b_cyc("rst_after2", ZERO);
        b_mem_rdata = 32'h4444_5555;
        b_cyc("rst_fresh_rvalid", exp_o(0,0,0,1,0,0, 32'h0, 32'h4444_5555, 32'h0, 32'h0, 4'h0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
